spin_majority_sampler: RTL and testbench

- Sequential, parametrised successor to the fixed 7-sample spin majority check.
- Accumulates a run-time-programmable number of samples of the live spin vector from the Ising core over successive SAMPLE_EN strobes, then votes each spin against a half-count threshold.
- Provides programmable tie resolution, a START/BUSY/VALID handshake and a unanimity flag.
- Sits between the core's spin outputs and the readout/scan-out logic.

---
 rtl/spin_vote_pkg.sv | 18 +
 rtl/spin_vote_cell.sv | 51 +++++
 rtl/spin_majority_sampler.sv | 155 +++++++++++++++
 tb/tb_spin_majority_sampler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spin_vote_pkg.sv
// rtl/spin_vote_pkg.sv - shared types and constants for the spin majority sampler
package spin_vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_VOTE  = 2'd2
    } vote_state_t;

    localparam logic TIE_ZERO = 1'b0;
    localparam logic TIE_HOLD = 1'b1;

    // Counter width able to hold every count from 0 up to max_samples inclusive
    function automatic int calc_cnt_w(input int max_samples);
        return $clog2(max_samples + 1);
    endfunction

endpackage

// File: rtl/spin_vote_cell.sv
// rtl/spin_vote_cell.sv - per-spin ones counter with half-count threshold vote
module spin_vote_cell
    import spin_vote_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_n,
    input  logic             i_tie_sel,
    input  logic             i_prev,
    output logic             o_result,
    output logic             o_extreme
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_twice;
    logic [CNT_W:0]   w_n_ext;

    // Count the ones seen on this spin since the run started
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // One extra bit keeps 2*cnt exact, so the compare never wraps
    assign w_twice = {r_cnt, 1'b0};
    assign w_n_ext = {1'b0, i_n};

    // Majority against n; an exact half is a tie that either clears or holds the old bit
    always_comb begin
        o_result = 1'b0;
        if (w_twice > w_n_ext) begin
            o_result = 1'b1;
        end else if (w_twice < w_n_ext) begin
            o_result = 1'b0;
        end else begin
            o_result = (i_tie_sel == TIE_HOLD) ? i_prev : TIE_ZERO;
        end
    end

    assign o_extreme = (r_cnt == '0) || (r_cnt == i_n);

endmodule

// File: rtl/spin_majority_sampler.sv
// rtl/spin_majority_sampler.sv - multi-sample majority vote over the Ising core spin vector
module spin_majority_sampler
    import spin_vote_pkg::*;
#(
    parameter int CORE_SIZE   = 64,
    parameter int MAX_SAMPLES = 15,
    parameter int CNT_W       = calc_cnt_w(MAX_SAMPLES)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [CNT_W-1:0]     NUM_SAMPLES,
    input  logic                 TIE_SEL,
    input  logic                 SAMPLE_EN,
    input  logic [CORE_SIZE-1:0] SPIN_IN,
    output logic                 BUSY,
    output logic [CORE_SIZE-1:0] SPIN_OUT,
    output logic                 SPIN_VALID,
    output logic                 UNANIMOUS
);

    vote_state_t          r_state;
    vote_state_t          w_next_state;
    logic [CNT_W-1:0]     r_n;
    logic [CNT_W-1:0]     r_idx;
    logic [CNT_W-1:0]     w_n_clamped;
    logic [CORE_SIZE-1:0] r_spin_out;
    logic                 r_spin_valid;
    logic                 r_unanimous;
    logic                 w_accept;
    logic                 w_take;
    logic                 w_vote;
    logic                 w_last;
    logic [CORE_SIZE-1:0] w_result;
    logic [CORE_SIZE-1:0] w_extreme;

    // When the counter width can exactly represent MAX_SAMPLES no request can exceed it
    generate
        if (MAX_SAMPLES >= (2 ** CNT_W) - 1) begin : g_no_clamp
            assign w_n_clamped = NUM_SAMPLES;
        end else begin : g_clamp
            localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_SAMPLES);
            assign w_n_clamped = (NUM_SAMPLES > MAX_N) ? MAX_N : NUM_SAMPLES;
        end
    endgenerate

    assign w_last = w_take && (r_idx == (r_n - CNT_W'(1)));

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: IDLE -> ACCUM on a nonzero START, ACCUM -> VOTE on the n-th sample, VOTE lasts one cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START && (NUM_SAMPLES != '0)) begin
                    w_next_state = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_last) begin
                    w_next_state = ST_VOTE;
                end
            end
            ST_VOTE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State-decoded strobes; START and SAMPLE_EN only matter in their own state
    always_comb begin
        BUSY     = 1'b0;
        w_accept = 1'b0;
        w_take   = 1'b0;
        w_vote   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = START && (NUM_SAMPLES != '0);
            end
            ST_ACCUM: begin
                BUSY   = 1'b1;
                w_take = SAMPLE_EN;
            end
            ST_VOTE: begin
                BUSY   = 1'b1;
                w_vote = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    // Latch the run length on START and track how many samples have been taken
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_n   <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_n   <= w_n_clamped;
            r_idx <= '0;
        end else if (w_take) begin
            r_idx <= r_idx + CNT_W'(1);
        end
    end

    generate
        for (genvar k = 0; k < CORE_SIZE; k++) begin : g_cell
            spin_vote_cell #(
                .CNT_W (CNT_W)
            ) u_cell (
                .i_clk     (CLK),
                .i_rst     (RST),
                .i_clr     (w_accept),
                .i_inc     (w_take & SPIN_IN[k]),
                .i_n       (r_n),
                .i_tie_sel (TIE_SEL),
                .i_prev    (r_spin_out[k]),
                .o_result  (w_result[k]),
                .o_extreme (w_extreme[k])
            );
        end
    endgenerate

    // Capture the vote during the VOTE cycle and pulse valid alongside it
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_spin_out   <= '0;
            r_unanimous  <= 1'b0;
            r_spin_valid <= 1'b0;
        end else begin
            r_spin_valid <= w_vote;
            if (w_vote) begin
                r_spin_out  <= w_result;
                r_unanimous <= &w_extreme;
            end
        end
    end

    assign SPIN_OUT   = r_spin_out;
    assign SPIN_VALID = r_spin_valid;
    assign UNANIMOUS  = r_unanimous;

endmodule

// File: tb/tb_spin_majority_sampler.sv
// tb/tb_spin_majority_sampler.sv - self-checking bench for spin_majority_sampler
module tb_spin_majority_sampler;

    localparam int CORE_SIZE   = 64;
    localparam int MAX_SAMPLES = 15;
    localparam int CNT_W       = 4;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 START;
    logic [CNT_W-1:0]     NUM_SAMPLES;
    logic                 TIE_SEL;
    logic                 SAMPLE_EN;
    logic [CORE_SIZE-1:0] SPIN_IN;
    logic                 BUSY;
    logic [CORE_SIZE-1:0] SPIN_OUT;
    logic                 SPIN_VALID;
    logic                 UNANIMOUS;

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    int vc0;

    logic                 chk_en = 1'b0;
    logic                 exp_busy;
    logic                 exp_valid;
    logic                 exp_unan;
    logic [CORE_SIZE-1:0] exp_out;

    logic [CORE_SIZE-1:0] smp_q[$];
    int                   gap_q[$];
    bit                   mid_start;

    always #5 CLK = ~CLK;

    spin_majority_sampler #(
        .CORE_SIZE   (CORE_SIZE),
        .MAX_SAMPLES (MAX_SAMPLES)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .NUM_SAMPLES (NUM_SAMPLES),
        .TIE_SEL     (TIE_SEL),
        .SAMPLE_EN   (SAMPLE_EN),
        .SPIN_IN     (SPIN_IN),
        .BUSY        (BUSY),
        .SPIN_OUT    (SPIN_OUT),
        .SPIN_VALID  (SPIN_VALID),
        .UNANIMOUS   (UNANIMOUS)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle after reset, all outputs must match the model's expectations
    always @(negedge CLK) begin
        if (chk_en) begin
            if (SPIN_VALID === 1'b1) valid_cnt++;
            chk("busy", 64'(BUSY), 64'(exp_busy));
            chk("spin_valid", 64'(SPIN_VALID), 64'(exp_valid));
            chk("spin_out", SPIN_OUT, exp_out);
            chk("unanimous", 64'(UNANIMOUS), 64'(exp_unan));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        exp_valid = 1'b0;
    endtask

    function automatic logic [63:0] mk(input int i, input logic [3:0] low);
        logic [63:0] p;
        p = 64'hA5C3_0F96_3C5A_E17B;
        for (int j = 0; j < i; j++) p = {p[58:0], p[63:59]};
        return {p[63:4], low};
    endfunction

    // Majority of the first n samples per spin, from plain ones counts
    function automatic void model_vote(input int n, input logic tie, input logic [63:0] prev,
                                       output logic [63:0] res, output logic un);
        un = 1'b1;
        for (int k = 0; k < CORE_SIZE; k++) begin
            int c;
            c = 0;
            for (int i = 0; i < n; i++) c += int'(smp_q[i][k]);
            if (2 * c > n)      res[k] = 1'b1;
            else if (2 * c < n) res[k] = 1'b0;
            else                res[k] = tie ? prev[k] : 1'b0;
            if (!(c == 0 || c == n)) un = 1'b0;
        end
    endfunction

    // One full run; returns just after the edge that raises SPIN_VALID
    task automatic run_vote(input int num, input logic tie);
        int n;
        int g;
        logic [63:0] res;
        logic un;
        n = (num > MAX_SAMPLES) ? MAX_SAMPLES : num;
        TIE_SEL = tie;
        START = 1'b1;
        NUM_SAMPLES = num[3:0];
        tick();
        exp_busy = 1'b1;
        START = 1'b0;
        for (int i = 0; i < n; i++) begin
            g = (i < gap_q.size()) ? gap_q[i] : 0;
            for (int j = 0; j < g; j++) begin
                SAMPLE_EN = 1'b0;
                if (mid_start && i == 2 && j == 0) begin
                    START = 1'b1;
                    NUM_SAMPLES = 4'd2;
                end
                tick();
                START = 1'b0;
            end
            SAMPLE_EN = 1'b1;
            SPIN_IN = smp_q[i];
            tick();
        end
        SAMPLE_EN = 1'b0;
        SPIN_IN = ~SPIN_IN;
        model_vote(n, tie, exp_out, res, un);
        tick();
        exp_busy = 1'b0;
        exp_valid = 1'b1;
        exp_out = res;
        exp_unan = un;
    endtask

    initial begin
        logic [63:0] res_pin;
        logic un_pin;

        RST = 1'b1;
        START = 1'b0;
        NUM_SAMPLES = '0;
        TIE_SEL = 1'b0;
        SAMPLE_EN = 1'b0;
        SPIN_IN = '0;
        mid_start = 1'b0;
        tick();
        tick();
        exp_busy = 1'b0;
        exp_valid = 1'b0;
        exp_out = '0;
        exp_unan = 1'b0;
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_out", SPIN_OUT, 64'd0);
        chk("reset_valid", 64'(SPIN_VALID), 64'd0);
        chk("reset_unan", 64'(UNANIMOUS), 64'd0);
        chk_en = 1'b1;
        RST = 1'b0;
        tick();

        // Legacy 7-sample equivalence
        smp_q = {mk(0, 4'hD), mk(1, 4'hD), mk(2, 4'hD), mk(3, 4'hD),
                 mk(4, 4'hE), mk(5, 4'h6), mk(6, 4'hE)};
        gap_q = {};
        model_vote(7, 1'b0, 64'd0, res_pin, un_pin);
        chk("model_legacy_bits", 64'(res_pin[3:0]), 64'hD);
        chk("model_legacy_unan", 64'(un_pin), 64'd0);
        vc0 = valid_cnt;
        run_vote(7, 1'b0);
        chk("legacy_valid_at_t1", 64'(SPIN_VALID), 64'd1);
        chk("legacy_bits", 64'(SPIN_OUT[2:0]), 64'b101);
        chk("legacy_unan", 64'(UNANIMOUS), 64'd0);
        tick();
        tick();
        chk("legacy_one_pulse", 64'(valid_cnt - vc0), 64'd1);

        // Reset mid-run after 3 of 7 samples
        vc0 = valid_cnt;
        START = 1'b1;
        NUM_SAMPLES = 4'd7;
        tick();
        exp_busy = 1'b1;
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            SAMPLE_EN = 1'b1;
            SPIN_IN = smp_q[i];
            tick();
        end
        SAMPLE_EN = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_busy = 1'b0;
        exp_out = '0;
        exp_unan = 1'b0;
        repeat (20) tick();
        chk("rst_mid_busy", 64'(BUSY), 64'd0);
        chk("rst_mid_out", SPIN_OUT, 64'd0);
        chk("rst_mid_no_valid", 64'(valid_cnt - vc0), 64'd0);

        // Ties at n=4, with n=1 runs setting up the previous bit
        smp_q = {mk(10, 4'h1), mk(11, 4'h1), mk(12, 4'h0), mk(13, 4'h0)};
        run_vote(4, 1'b0);
        chk("tie_zero", 64'(SPIN_OUT[0]), 64'd0);
        tick();
        smp_q = {mk(14, 4'h1)};
        run_vote(1, 1'b0);
        chk("n1_pass", SPIN_OUT, mk(14, 4'h1));
        chk("n1_unan", 64'(UNANIMOUS), 64'd1);
        tick();
        smp_q = {mk(15, 4'h0), mk(16, 4'h1), mk(17, 4'h0), mk(18, 4'h1)};
        run_vote(4, 1'b1);
        chk("tie_hold_1", 64'(SPIN_OUT[0]), 64'd1);
        tick();
        smp_q = {mk(19, 4'h0)};
        run_vote(1, 1'b0);
        chk("n1_pass_b", SPIN_OUT, mk(19, 4'h0));
        tick();
        smp_q = {mk(20, 4'h1), mk(21, 4'h0), mk(22, 4'h1), mk(23, 4'h0)};
        run_vote(4, 1'b1);
        chk("tie_hold_0", 64'(SPIN_OUT[0]), 64'd0);
        tick();

        // Gapped strobes with a START pulse mid-run
        smp_q = {mk(24, 4'h1), mk(25, 4'h0), mk(26, 4'h1), mk(27, 4'h0), mk(28, 4'h1)};
        gap_q = {0, 3, 1, 2, 0};
        mid_start = 1'b1;
        run_vote(5, 1'b0);
        chk("gapped_bit0", 64'(SPIN_OUT[0]), 64'd1);
        mid_start = 1'b0;
        gap_q = {};
        tick();

        // NUM_SAMPLES=0 is ignored; SAMPLE_EN in IDLE is ignored
        START = 1'b1;
        NUM_SAMPLES = 4'd0;
        tick();
        START = 1'b0;
        chk("num0_idle", 64'(BUSY), 64'd0);
        SAMPLE_EN = 1'b1;
        SPIN_IN = '1;
        tick();
        tick();
        SAMPLE_EN = 1'b0;
        chk("idle_sample_busy", 64'(BUSY), 64'd0);

        // Full 15-sample run
        smp_q = {};
        for (int i = 0; i < 15; i++)
            smp_q.push_back(mk(30 + i, {2'b00, (i < 7) ? 1'b1 : 1'b0, (i < 8) ? 1'b1 : 1'b0}));
        run_vote(15, 1'b0);
        chk("max15_bits", 64'(SPIN_OUT[1:0]), 64'b01);
        tick();

        // Back-to-back: START in the SPIN_VALID cycle, counters cleared for the second run
        smp_q = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        run_vote(3, 1'b0);
        chk("b2b_first", SPIN_OUT, 64'hFFFF_FFFF_FFFF_FFFF);
        smp_q = {64'd0, 64'd0, 64'd0};
        run_vote(3, 1'b0);
        chk("b2b_second", SPIN_OUT, 64'd0);
        chk("b2b_unan", 64'(UNANIMOUS), 64'd1);
        repeat (3) tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
